// File: rtl/opl_op_output.sv
// FM operator output stage: phase -> log-sin -> +attenuation -> exp -> signed 13-bit sample.
// Optional feature macro OPL_WAVEFORMS_EN enables ws-driven waveform shaping in stage A.

module lut_logsin (
    input  logic [7:0]  idx,
    output logic [11:0] val
);
    // round(-log2(sin((idx + 0.5) / 256 * pi / 2)) * 256), quarter wave
    localparam logic [11:0] ROM [256] = '{
        12'h859, 12'h6c3, 12'h607, 12'h58b, 12'h52e, 12'h4e4, 12'h4a6, 12'h471,
        12'h443, 12'h41a, 12'h3f5, 12'h3d3, 12'h3b5, 12'h398, 12'h37e, 12'h365,
        12'h34e, 12'h339, 12'h324, 12'h311, 12'h2ff, 12'h2ed, 12'h2dc, 12'h2cd,
        12'h2bd, 12'h2af, 12'h2a0, 12'h293, 12'h286, 12'h279, 12'h26d, 12'h261,
        12'h256, 12'h24b, 12'h240, 12'h236, 12'h22c, 12'h222, 12'h218, 12'h20f,
        12'h206, 12'h1fd, 12'h1f5, 12'h1ec, 12'h1e4, 12'h1dc, 12'h1d4, 12'h1cd,
        12'h1c5, 12'h1be, 12'h1b7, 12'h1b0, 12'h1a9, 12'h1a2, 12'h19b, 12'h195,
        12'h18f, 12'h188, 12'h182, 12'h17c, 12'h177, 12'h171, 12'h16b, 12'h166,
        12'h160, 12'h15b, 12'h155, 12'h150, 12'h14b, 12'h146, 12'h141, 12'h13c,
        12'h137, 12'h133, 12'h12e, 12'h129, 12'h125, 12'h121, 12'h11c, 12'h118,
        12'h114, 12'h10f, 12'h10b, 12'h107, 12'h103, 12'h0ff, 12'h0fb, 12'h0f8,
        12'h0f4, 12'h0f0, 12'h0ec, 12'h0e9, 12'h0e5, 12'h0e2, 12'h0de, 12'h0db,
        12'h0d7, 12'h0d4, 12'h0d1, 12'h0cd, 12'h0ca, 12'h0c7, 12'h0c4, 12'h0c1,
        12'h0be, 12'h0bb, 12'h0b8, 12'h0b5, 12'h0b2, 12'h0af, 12'h0ac, 12'h0a9,
        12'h0a7, 12'h0a4, 12'h0a1, 12'h09f, 12'h09c, 12'h099, 12'h097, 12'h094,
        12'h092, 12'h08f, 12'h08d, 12'h08a, 12'h088, 12'h086, 12'h083, 12'h081,
        12'h07f, 12'h07d, 12'h07a, 12'h078, 12'h076, 12'h074, 12'h072, 12'h070,
        12'h06e, 12'h06c, 12'h06a, 12'h068, 12'h066, 12'h064, 12'h062, 12'h060,
        12'h05e, 12'h05c, 12'h05b, 12'h059, 12'h057, 12'h055, 12'h053, 12'h052,
        12'h050, 12'h04e, 12'h04d, 12'h04b, 12'h04a, 12'h048, 12'h046, 12'h045,
        12'h043, 12'h042, 12'h040, 12'h03f, 12'h03e, 12'h03c, 12'h03b, 12'h039,
        12'h038, 12'h037, 12'h035, 12'h034, 12'h033, 12'h031, 12'h030, 12'h02f,
        12'h02e, 12'h02d, 12'h02b, 12'h02a, 12'h029, 12'h028, 12'h027, 12'h026,
        12'h025, 12'h024, 12'h023, 12'h022, 12'h021, 12'h020, 12'h01f, 12'h01e,
        12'h01d, 12'h01c, 12'h01b, 12'h01a, 12'h019, 12'h018, 12'h017, 12'h017,
        12'h016, 12'h015, 12'h014, 12'h014, 12'h013, 12'h012, 12'h011, 12'h011,
        12'h010, 12'h00f, 12'h00f, 12'h00e, 12'h00d, 12'h00d, 12'h00c, 12'h00c,
        12'h00b, 12'h00a, 12'h00a, 12'h009, 12'h009, 12'h008, 12'h008, 12'h007,
        12'h007, 12'h007, 12'h006, 12'h006, 12'h005, 12'h005, 12'h005, 12'h004,
        12'h004, 12'h004, 12'h003, 12'h003, 12'h003, 12'h002, 12'h002, 12'h002,
        12'h002, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001, 12'h001,
        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000
    };

    assign val = ROM[idx];
endmodule

module opl_op_output (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        in_valid,
    input  logic [9:0]  phase,
    input  logic [8:0]  atten,
    input  logic [1:0]  ws,
    output logic        out_valid,
    output logic [12:0] out_sample
);
    localparam int STAGES = 4;

    // Exponent table entries are fixed at elaboration; only constants reach hardware.
    function automatic logic [9:0] exp_entry(input int i);
        real v;
        v = (2.0 ** (real'(i) / 256.0) - 1.0) * 1024.0;
        return 10'($rtoi(v + 0.5));
    endfunction

    logic [9:0] exp_rom [256];
    for (genvar g = 0; g < 256; g++) begin : g_exp
        assign exp_rom[g] = exp_entry(g);
    end

    logic [STAGES-1:0] vld_pipe;

    // stage A
    logic [7:0]  a_idx_d, a_idx;
    logic        a_neg_d, a_mute_d, a_neg, a_mute;
    logic [8:0]  a_atten;
    // stage B
    logic [11:0] logsin_v;
    logic [12:0] b_total;
    logic        b_neg, b_mute;
    // stage C
    logic [7:0]  c_f;
    logic [4:0]  c_e;
    logic [11:0] mant, mag_d, c_mag;
    logic        c_neg, c_mute;

    always_comb begin
        a_idx_d  = phase[8] ? ~phase[7:0] : phase[7:0];
        a_neg_d  = phase[9];
        a_mute_d = 1'b0;
`ifdef OPL_WAVEFORMS_EN
        case (ws)
            2'd1: a_mute_d = phase[9];
            2'd2: a_neg_d  = 1'b0;
            2'd3: begin
                a_mute_d = phase[8];
                a_neg_d  = 1'b0;
            end
            default: ;
        endcase
`endif
    end

`ifndef OPL_WAVEFORMS_EN
    logic unused_ws;
    assign unused_ws = ^ws;
`endif

    lut_logsin u_logsin (
        .idx (a_idx),
        .val (logsin_v)
    );

    always_comb begin
        c_f   = b_total[7:0];
        c_e   = b_total[12:8];
        mant  = {1'b1, exp_rom[~c_f], 1'b0};
        mag_d = (c_e >= 5'd12) ? 12'd0 : (mant >> c_e);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            a_idx      <= '0;
            a_neg      <= 1'b0;
            a_mute     <= 1'b0;
            a_atten    <= '0;
            b_total    <= '0;
            b_neg      <= 1'b0;
            b_mute     <= 1'b0;
            c_mag      <= '0;
            c_neg      <= 1'b0;
            c_mute     <= 1'b0;
            out_sample <= '0;
        end else if (ce) begin
            vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
            a_idx    <= a_idx_d;
            a_neg    <= a_neg_d;
            a_mute   <= a_mute_d;
            a_atten  <= atten;
            b_total  <= {1'b0, logsin_v} + {1'b0, a_atten, 3'b000};
            b_neg    <= a_neg;
            b_mute   <= a_mute;
            c_mag    <= mag_d;
            c_neg    <= b_neg;
            c_mute   <= b_mute;
            // Output holds across bubbles so downstream sees the last real sample.
            if (vld_pipe[STAGES-2]) begin
                if (c_mute)     out_sample <= '0;
                else if (c_neg) out_sample <= 13'd0 - {1'b0, c_mag};
                else            out_sample <= {1'b0, c_mag};
            end
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_opl_op_output.sv
// Directed bench for opl_op_output with hand-computed expected samples.
module tb_opl_op_output;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [9:0]  phase = '0;
    logic [8:0]  atten = '0;
    logic [1:0]  ws = '0;
    logic        out_valid;
    logic [12:0] out_sample;

    int nchk = 0;
    int nerr = 0;
    logic [12:0] q[$];
    logic [12:0] fs;
    logic        fv;
    logic [12:0] stall_exp [3];

    opl_op_output dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .in_valid   (in_valid),
        .phase      (phase),
        .atten      (atten),
        .ws         (ws),
        .out_valid  (out_valid),
        .out_sample (out_sample)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then record any output produced by that edge.
    task automatic step(input logic c, input logic v, input logic [9:0] ph,
                        input logic [8:0] at, input logic [1:0] w);
        @(negedge clk);
        ce = c; in_valid = v; phase = ph; atten = at; ws = w;
        @(posedge clk);
        #1;
        if (c && out_valid) q.push_back(out_sample);
    endtask

    task automatic one(input string tag, input logic [9:0] ph, input logic [8:0] at,
                       input logic [1:0] w, input logic [12:0] exp);
        q.delete();
        step(1'b1, 1'b1, ph, at, w);
        repeat (3) step(1'b1, 1'b0, 10'h0, 9'h0, 2'd0);
        chk({tag, "_cnt"}, 13'(q.size()), 13'd1);
        chk({tag, "_vld"}, {12'b0, out_valid}, 13'd1);
        chk(tag, out_sample, exp);
        step(1'b1, 1'b0, 10'h0, 9'h0, 2'd0);
        chk({tag, "_drop"}, {12'b0, out_valid}, 13'd0);
        chk({tag, "_hold"}, out_sample, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", {12'b0, out_valid}, 13'd0);
        chk("rst_smp", out_sample, 13'd0);
        @(negedge clk);
        rst_n = 1'b1;

        one("pos_peak", 10'h100, 9'h000, 2'd0, 13'd4084);
        one("neg_peak", 10'h300, 9'h000, 2'd0, 13'h100C);
        one("att_100",  10'h100, 9'h100, 2'd0, 13'd15);
        one("ph_000",   10'h000, 9'h000, 2'd0, 13'd12);
        one("ph_200",   10'h200, 9'h000, 2'd0, 13'h1FF4);
        one("ph_0ff",   10'h0FF, 9'h000, 2'd0, 13'd4084);
        one("ph_3ff",   10'h3FF, 9'h000, 2'd0, 13'h1FF4);
        one("att_max",  10'h100, 9'h1FF, 2'd0, 13'd0);

        // stall mid-stream
        q.delete();
        stall_exp[0] = 13'd4084; stall_exp[1] = 13'h100C; stall_exp[2] = 13'd4084;
        step(1'b1, 1'b1, 10'h100, 9'h0, 2'd0);
        step(1'b1, 1'b1, 10'h300, 9'h0, 2'd0);
        fv = out_valid;
        fs = out_sample;
        repeat (3) begin
            step(1'b0, 1'b1, 10'h000, 9'h0, 2'd0);
            chk("stall_vld", {12'b0, out_valid}, {12'b0, fv});
            chk("stall_smp", out_sample, fs);
        end
        step(1'b1, 1'b1, 10'h100, 9'h0, 2'd0);
        repeat (5) step(1'b1, 1'b0, 10'h0, 9'h0, 2'd0);
        chk("stall_cnt", 13'(q.size()), 13'd3);
        for (int i = 0; i < 3; i++)
            chk("stall_seq", (i < q.size()) ? q[i] : 13'h1555, stall_exp[i]);

        // reset while the pipe is full
        repeat (5) step(1'b1, 1'b1, 10'h100, 9'h0, 2'd0);
        chk("pre_rst", out_sample, 13'd4084);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {12'b0, out_valid}, 13'd0);
        chk("mid_rst_smp", out_sample, 13'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        q.delete();
        step(1'b1, 1'b1, 10'h300, 9'h0, 2'd0);
        repeat (2) step(1'b1, 1'b0, 10'h0, 9'h0, 2'd0);
        chk("post_rst_early", {12'b0, out_valid}, 13'd0);
        step(1'b1, 1'b0, 10'h0, 9'h0, 2'd0);
        chk("post_rst_vld", {12'b0, out_valid}, 13'd1);
        chk("post_rst_smp", out_sample, 13'h100C);

`ifdef OPL_WAVEFORMS_EN
        one("ws1_half", 10'h300, 9'h000, 2'd1, 13'd0);
        one("ws2_abs",  10'h300, 9'h000, 2'd2, 13'd4084);
        one("ws3_pul",  10'h300, 9'h000, 2'd3, 13'd0);
        q.delete();
        step(1'b1, 1'b1, 10'h080, 9'h0, 2'd3);
        repeat (3) step(1'b1, 1'b0, 10'h0, 9'h0, 2'd0);
        chk("ws3_pos", {12'b0, (out_valid && out_sample != 13'd0 && !out_sample[12])}, 13'd1);
`else
        one("ws_off", 10'h300, 9'h000, 2'd1, 13'h100C);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
